snake_body_engine: RTL and testbench

- Parametrised successor to the snake datapath.
- Stores the snake body in a circular buffer of grid-cell coordinates (head pointer plus length) instead of shifting RAM every move.
- On each game tick it computes the new head, checks wall and self collision with a sequential body scan, handles food growth, then commits.
- Sits between the game-tick FSM and the VGA draw sequencer; the draw sequencer reads segments through a 1-cycle-latency read port.

---
 rtl/snake_body_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// Snake body engine: circular-buffer body store with per-tick head move, wall/self collision scan and food growth.
// Latency: INIT_LEN cycles after reset; a step completes at most MAX_LEN+3 cycles after step_req; read port is 1 cycle.
// Backpressure: none. step_req is dropped while busy, and the read port is always available.
// Optional feature: define WRAP_EN to make the grid edges wrap around instead of killing the snake.
module snake_body_engine #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int CELL_PX  = 4,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 15,
  parameter int START_Y  = 15,
  localparam int XW  = $clog2(GRID_W),
  localparam int YW  = $clog2(GRID_H),
  localparam int LW  = $clog2(MAX_LEN),
  localparam int PW  = $clog2(CELL_PX),
  localparam int PXW = XW + PW,
  localparam int PYW = YW + PW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_req,
  input  logic [1:0]     dir,
  input  logic [XW-1:0]  food_x,
  input  logic [YW-1:0]  food_y,
  input  logic [LW-1:0]  seg_idx,
  output logic [PXW-1:0] seg_x_px,
  output logic [PYW-1:0] seg_y_px,
  output logic           seg_valid,
  output logic           busy,
  output logic           step_done,
  output logic           ate,
  output logic           dead,
  output logic [LW:0]    length
);

  localparam logic [1:0]    DIR_UP    = 2'd0;
  localparam logic [1:0]    DIR_DOWN  = 2'd1;
  localparam logic [1:0]    DIR_LEFT  = 2'd2;
  localparam logic [1:0]    DIR_RIGHT = 2'd3;
  localparam logic [LW:0]   FULL_LEN  = (LW+1)'(MAX_LEN);
  localparam logic [LW:0]   INIT_LAST = (LW+1)'(INIT_LEN - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_COMMIT,
    S_DEAD
  } state_t;

  state_t state, state_n;

  // Body storage, indexed physically; logical segment k lives at head_ptr+k.
  logic [XW-1:0] mem_x [MAX_LEN];
  logic [YW-1:0] mem_y [MAX_LEN];

  logic [LW-1:0] head_ptr;
  logic [XW-1:0] head_x, new_x, calc_x, init_x;
  logic [YW-1:0] head_y, new_y, calc_y;
  logic [1:0]    cur_dir;
  logic          grow_q, food_q;
  logic [LW:0]   scan_idx, scan_cnt, calc_cnt;
  logic          calc_wall, calc_food, calc_grow;
  logic          reverse, scan_hit;
  logic [LW-1:0] scan_addr, rd_addr, wr_ptr;

  assign busy      = (state != S_IDLE);
  assign reverse   = (dir[1] == cur_dir[1]) && (dir[0] != cur_dir[0]);
  assign scan_addr = head_ptr + scan_idx[LW-1:0];
  assign rd_addr   = head_ptr + seg_idx;
  assign wr_ptr    = head_ptr - LW'(1);
  assign init_x    = XW'(START_X - int'(length));
  assign scan_hit  = (mem_x[scan_addr] == new_x) && (mem_y[scan_addr] == new_y);

  // Candidate head cell; edge tests come before any decrement so nothing underflows.
  always_comb begin
    calc_x    = head_x;
    calc_y    = head_y;
    calc_wall = 1'b0;
    case (cur_dir)
      DIR_UP: begin
        if (head_y == '0) begin
`ifdef WRAP_EN
          calc_y = Y_MAX;
`else
          calc_wall = 1'b1;
`endif
        end else begin
          calc_y = head_y - YW'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_MAX) begin
`ifdef WRAP_EN
          calc_y = '0;
`else
          calc_wall = 1'b1;
`endif
        end else begin
          calc_y = head_y + YW'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
`ifdef WRAP_EN
          calc_x = X_MAX;
`else
          calc_wall = 1'b1;
`endif
        end else begin
          calc_x = head_x - XW'(1);
        end
      end
      default: begin
        if (head_x == X_MAX) begin
`ifdef WRAP_EN
          calc_x = '0;
`else
          calc_wall = 1'b1;
`endif
        end else begin
          calc_x = head_x + XW'(1);
        end
      end
    endcase
  end

  // Food/growth decision and scan length; the tail is excluded when it vacates this tick.
  always_comb begin
    calc_food = (calc_x == food_x) && (calc_y == food_y);
    calc_grow = calc_food && (length < FULL_LEN);
    calc_cnt  = calc_grow ? length : (length - (LW+1)'(1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_INIT;
    else      state <= state_n;
  end

  // FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_INIT:   if (length == INIT_LAST) state_n = S_IDLE;
      S_IDLE:   if (step_req) state_n = S_CALC;
      S_CALC: begin
        if (calc_wall)            state_n = S_DEAD;
        else if (calc_cnt == '0)  state_n = S_COMMIT;
        else                      state_n = S_SCAN;
      end
      S_SCAN: begin
        if (scan_hit)                                state_n = S_DEAD;
        else if (scan_idx == scan_cnt - (LW+1)'(1))  state_n = S_COMMIT;
      end
      S_COMMIT: state_n = S_IDLE;
      S_DEAD:   state_n = S_DEAD;
      default:  state_n = S_INIT;
    endcase
  end

  // Control/datapath registers: head, pointer, length, scan bookkeeping and status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_ptr  <= '0;
      length    <= '0;
      cur_dir   <= DIR_RIGHT;
      head_x    <= '0;
      head_y    <= '0;
      new_x     <= '0;
      new_y     <= '0;
      grow_q    <= 1'b0;
      food_q    <= 1'b0;
      scan_idx  <= '0;
      scan_cnt  <= '0;
      step_done <= 1'b0;
      ate       <= 1'b0;
      dead      <= 1'b0;
    end else begin
      step_done <= 1'b0;
      ate       <= 1'b0;
      case (state)
        S_INIT: begin
          length <= length + (LW+1)'(1);
          if (length == '0) begin
            head_x <= XW'(START_X);
            head_y <= YW'(START_Y);
          end
        end
        S_IDLE: begin
          if (step_req && !reverse) cur_dir <= dir;
        end
        S_CALC: begin
          new_x    <= calc_x;
          new_y    <= calc_y;
          grow_q   <= calc_grow;
          food_q   <= calc_food;
          scan_cnt <= calc_cnt;
          scan_idx <= '0;
          if (calc_wall) begin
            dead      <= 1'b1;
            step_done <= 1'b1;
          end
        end
        S_SCAN: begin
          scan_idx <= scan_idx + (LW+1)'(1);
          if (scan_hit) begin
            dead      <= 1'b1;
            step_done <= 1'b1;
          end
        end
        S_COMMIT: begin
          head_ptr  <= wr_ptr;
          head_x    <= new_x;
          head_y    <= new_y;
          length    <= length + (LW+1)'(grow_q);
          step_done <= 1'b1;
          ate       <= food_q;
        end
        default: ;
      endcase
    end
  end

  // Body writes: initial segments laid out leftward from the start cell, new head one slot before head_ptr.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == S_INIT) begin
        mem_x[length[LW-1:0]] <= init_x;
        mem_y[length[LW-1:0]] <= YW'(START_Y);
      end else if (state == S_COMMIT) begin
        mem_x[wr_ptr] <= new_x;
        mem_y[wr_ptr] <= new_y;
      end
    end
  end

  // Registered read port for the draw sequencer; sees pre-commit contents during COMMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_x_px  <= '0;
      seg_y_px  <= '0;
      seg_valid <= 1'b0;
    end else begin
      seg_x_px  <= PXW'(mem_x[rd_addr]) * PXW'(CELL_PX);
      seg_y_px  <= PYW'(mem_y[rd_addr]) * PYW'(CELL_PX);
      seg_valid <= ({1'b0, seg_idx} < length);
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: directed steps with expected step results and segment reads queued,
// checked by independent monitors on step_done and on read-port returns.
module tb_snake_body_engine;
  localparam int XW  = 6;
  localparam int YW  = 5;
  localparam int LW  = 6;
  localparam int PXW = 8;
  localparam int PYW = 7;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           step_req = 1'b0;
  logic [1:0]     dir = 2'd0;
  logic [XW-1:0]  food_x = '0;
  logic [YW-1:0]  food_y = '0;
  logic [LW-1:0]  seg_idx = '0;
  logic [PXW-1:0] seg_x_px;
  logic [PYW-1:0] seg_y_px;
  logic           seg_valid, busy, step_done, ate, dead;
  logic [LW:0]    length;

  snake_body_engine dut (
    .clk(clk), .rst(rst), .step_req(step_req), .dir(dir),
    .food_x(food_x), .food_y(food_y), .seg_idx(seg_idx),
    .seg_x_px(seg_x_px), .seg_y_px(seg_y_px), .seg_valid(seg_valid),
    .busy(busy), .step_done(step_done), .ate(ate), .dead(dead), .length(length)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic ate; logic dead; logic [LW:0] len; } step_exp_t;
  typedef struct packed { logic valid; logic [PXW-1:0] x; logic [PYW-1:0] y; } rd_exp_t;

  step_exp_t step_q[$];
  rd_exp_t   rd_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Step monitor: every step_done pops one expected result.
  always @(negedge clk) begin : step_mon
    step_exp_t e;
    if (rst && step_done) begin
      done_cnt++;
      if (step_q.size() == 0) begin
        chk(1'b0, "unexpected_step_done", 1, 0);
      end else begin
        e = step_q.pop_front();
        chk(ate == e.ate, "step_ate", int'(ate), int'(e.ate));
        chk(dead == e.dead, "step_dead", int'(dead), int'(e.dead));
        chk(length == e.len, "step_length", int'(length), int'(e.len));
      end
    end
  end

  always @(posedge clk) rd_req_d <= rd_req;

  // Read monitor: one cycle after a read index is presented, compare the registered outputs.
  always @(negedge clk) begin : rd_mon
    rd_exp_t e;
    if (rd_req_d) begin
      if (rd_q.size() == 0) begin
        chk(1'b0, "unexpected_read", 1, 0);
      end else begin
        e = rd_q.pop_front();
        chk(seg_valid == e.valid, "seg_valid", int'(seg_valid), int'(e.valid));
        if (e.valid) begin
          chk(seg_x_px == e.x, "seg_x_px", int'(seg_x_px), int'(e.x));
          chk(seg_y_px == e.y, "seg_y_px", int'(seg_y_px), int'(e.y));
        end
      end
    end
  end

  // Read segment idx; expected cell (cx,cy) scaled by the 4-pixel cell size.
  task automatic rd(input int idx, input int v, input int cx, input int cy);
    rd_exp_t e;
    @(posedge clk); #1;
    seg_idx = LW'(idx);
    rd_req  = 1'b1;
    e.valid = (v != 0);
    e.x     = PXW'(cx * 4);
    e.y     = PYW'(cy * 4);
    rd_q.push_back(e);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  // Issue one step; optionally re-pulse step_req mid-step, which must be dropped.
  task automatic do_step(input int d, input int fx, input int fy, input int ea, input int ed,
                         input int el, input int lim, input int extra);
    step_exp_t e;
    int n;
    int start;
    bit got;
    @(posedge clk); #1;
    dir      = 2'(d);
    food_x   = XW'(fx);
    food_y   = YW'(fy);
    step_req = 1'b1;
    e.ate  = (ea != 0);
    e.dead = (ed != 0);
    e.len  = (LW+1)'(el);
    step_q.push_back(e);
    start = done_cnt;
    n = 0;
    got = 1'b0;
    while (!got && n < lim) begin
      @(posedge clk);
      n++;
      #1;
      step_req = (extra != 0) && (n == 2);
      #5;
      if (done_cnt != start) got = 1'b1;
    end
    step_req = 1'b0;
    chk(got, "step_latency", n, lim);
  endtask

  // Caller drives rst low; after cyc edges the block must be back in INIT with cleared status.
  task automatic reset_checks(input int cyc);
    repeat (cyc) @(posedge clk);
    #6;
    chk(length == 0, "rst_length", int'(length), 0);
    chk(dead == 1'b0, "rst_dead", int'(dead), 0);
    chk(step_done == 1'b0, "rst_step_done", int'(step_done), 0);
    chk(ate == 1'b0, "rst_ate", int'(ate), 0);
    chk(seg_valid == 1'b0, "rst_seg_valid", int'(seg_valid), 0);
    chk(busy == 1'b1, "rst_busy_init", int'(busy), 1);
  endtask

  task automatic release_init();
    int n;
    bit idle;
    rst = 1'b1;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 10) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy) idle = 1'b1;
    end
    chk(n == 3, "init_cycles", n, 3);
    chk(length == 3, "init_length", int'(length), 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_checks(2);
    release_init();
    rd(0, 1, 15, 15); rd(1, 1, 14, 15); rd(2, 1, 13, 15); rd(3, 0, 0, 0);

    do_step(3, 20, 20, 0, 0, 3, 6, 0);
    rd(0, 1, 16, 15); rd(1, 1, 15, 15); rd(2, 1, 14, 15);
    do_step(3, 17, 15, 1, 0, 4, 8, 1);
    rd(3, 1, 14, 15); rd(4, 0, 0, 0);
    do_step(2, 0, 0, 0, 0, 4, 8, 0);
    rd(0, 1, 18, 15);

    do_step(1, 0, 0, 0, 0, 4, 8, 0);
    do_step(2, 0, 0, 0, 0, 4, 8, 0);
    do_step(0, 0, 0, 0, 0, 4, 8, 0);
    rd(0, 1, 17, 15); rd(3, 1, 18, 15);

    do_step(0, 0, 0, 0, 0, 4, 8, 0);
    do_step(3, 18, 14, 1, 0, 5, 9, 0);
    do_step(1, 0, 0, 0, 0, 5, 9, 0);
    do_step(2, 0, 0, 0, 1, 5, 9, 0);
    rd(0, 1, 18, 15); rd(4, 1, 17, 16); rd(5, 0, 0, 0);

    @(posedge clk); #1;
    step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    repeat (8) @(posedge clk);
    #6;
    chk(dead == 1'b1, "dead_sticky", int'(dead), 1);
    chk(busy == 1'b1, "dead_busy", int'(busy), 1);

    @(posedge clk); #1;
    rst = 1'b0;
    reset_checks(1);
    release_init();

    @(posedge clk); #1;
    dir = 2'd3; food_x = '0; food_y = '0; step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_checks(1);
    release_init();

    for (int i = 0; i < 24; i++) do_step(3, 0, 0, 0, 0, 3, 6, 0);
    rd(0, 1, 39, 15);
`ifdef WRAP_EN
    do_step(3, 0, 0, 0, 0, 3, 6, 0);
    rd(0, 1, 0, 15); rd(1, 1, 39, 15);
    #6;
    chk(dead == 1'b0, "wrap_alive", int'(dead), 0);
`else
    do_step(3, 0, 0, 0, 1, 3, 6, 0);
    rd(0, 1, 39, 15); rd(1, 1, 38, 15);
    #6;
    chk(dead == 1'b1, "wall_dead", int'(dead), 1);
`endif

    repeat (4) @(posedge clk);
    #6;
    chk(step_q.size() == 0, "steps_outstanding", step_q.size(), 0);
    chk(rd_q.size() == 0, "reads_outstanding", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
